uart_cmd_parser: RTL and testbench

- Sits directly downstream of the uart block's RX FIFO and upstream of its TX FIFO.
- Pops received bytes and assembles fixed-length ASCII commands, then matches them against a small command table.
- Pushes an ASCII reply string into the TX FIFO and emits pass/fail debug toggles for the debug pins.

---
 rtl/uart_cmd_parser_pkg.sv | 32 +++
 rtl/uart_cmd_parser_if.sv | 31 +++
 rtl/uart_cmd_parser_reply_rom.sv | 57 +++++
 rtl/uart_cmd_parser.sv | 162 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command parser.
// Holds the FSM state encoding, the reply identifiers, the recognised
// command words and the length of each canned reply string.
package uart_cmd_pkg;

  // FSM states, kept as plain constants so older tools see a fixed encoding
  typedef logic [1:0] state_t;
  localparam state_t S_RECV  = 2'd0;
  localparam state_t S_GAP   = 2'd1;
  localparam state_t S_PARSE = 2'd2;
  localparam state_t S_REPLY = 2'd3;

  // Which canned reply string to send back
  typedef enum logic [1:0] {
    RPL_OK   = 2'd0,
    RPL_PONG = 2'd1,
    RPL_ERR  = 2'd2
  } reply_id_t;

  // Byte position inside a reply string (longest reply is 6 bytes)
  typedef logic [2:0] reply_idx_t;

  // Recognised commands, first received byte in the most significant position
  localparam logic [31:0] CMD_TEST = 32'h54455354;
  localparam logic [31:0] CMD_PING = 32'h50494E47;

  // Reply lengths: "OK\r\n", "PONG\r\n", "ERR\r\n"
  localparam int RPL_OK_LEN   = 4;
  localparam int RPL_PONG_LEN = 6;
  localparam int RPL_ERR_LEN  = 5;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// FIFO-side bundle of the UART command parser: RX FIFO pop interface and
// TX FIFO push interface. The parser is the master (it issues pops and
// pushes); the UART FIFOs are the slave.
interface uart_cmd_parser_if;

  logic       rx_fifo_empty;
  logic [7:0] rx_fifo_data_out;
  logic       rx_fifo_read_en;
  logic       tx_fifo_full;
  logic [7:0] tx_fifo_data_in;
  logic       tx_fifo_write_en;

  modport master (
    input  rx_fifo_empty,
    input  rx_fifo_data_out,
    input  tx_fifo_full,
    output rx_fifo_read_en,
    output tx_fifo_data_in,
    output tx_fifo_write_en
  );

  modport slave (
    output rx_fifo_empty,
    output rx_fifo_data_out,
    output tx_fifo_full,
    input  rx_fifo_read_en,
    input  tx_fifo_data_in,
    input  tx_fifo_write_en
  );

endinterface

// File: rtl/uart_cmd_parser_reply_rom.sv
// Reply string lookup: maps (reply id, byte index) to the ASCII byte to
// send and flags the final byte of the string. Purely combinational.
module cmd_reply_rom
  import uart_cmd_pkg::*;
(
  input  reply_id_t  reply_id,
  input  reply_idx_t reply_idx,
  output logic [7:0] reply_byte,
  output logic       reply_last
);

  // Table lookup with the end-of-string flag derived from each reply length
  always_comb begin
    reply_byte = 8'h00;
    reply_last = 1'b0;
    case (reply_id)
      RPL_OK: begin
        case (reply_idx)
          3'd0:    reply_byte = 8'h4F;
          3'd1:    reply_byte = 8'h4B;
          3'd2:    reply_byte = 8'h0D;
          3'd3:    reply_byte = 8'h0A;
          default: reply_byte = 8'h00;
        endcase
        reply_last = (reply_idx == 3'(RPL_OK_LEN - 1));
      end
      RPL_PONG: begin
        case (reply_idx)
          3'd0:    reply_byte = 8'h50;
          3'd1:    reply_byte = 8'h4F;
          3'd2:    reply_byte = 8'h4E;
          3'd3:    reply_byte = 8'h47;
          3'd4:    reply_byte = 8'h0D;
          3'd5:    reply_byte = 8'h0A;
          default: reply_byte = 8'h00;
        endcase
        reply_last = (reply_idx == 3'(RPL_PONG_LEN - 1));
      end
      RPL_ERR: begin
        case (reply_idx)
          3'd0:    reply_byte = 8'h45;
          3'd1:    reply_byte = 8'h52;
          3'd2:    reply_byte = 8'h52;
          3'd3:    reply_byte = 8'h0D;
          3'd4:    reply_byte = 8'h0A;
          default: reply_byte = 8'h00;
        endcase
        reply_last = (reply_idx == 3'(RPL_ERR_LEN - 1));
      end
      default: begin
        reply_byte = 8'h00;
        reply_last = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART command parser: pops fixed-length ASCII frames from the RX FIFO,
// matches them against "TEST"/"PING", pushes the reply string into the TX
// FIFO and flips a pass or fail toggle for the debug pins.
// A partial frame is dropped after TIMEOUT_MS of RX silence.
// Optional build macro UART_CMD_ECHO_EN: echo every popped byte to TX
// ahead of the reply.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int CMD_LENGTH      = 4,
  parameter int TIMEOUT_MS      = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  uart_cmd_parser_if.master      bus,
  output logic                   cmd_pass_toggle,
  output logic                   cmd_fail_toggle,
  output logic [7:0]             cmd_count
);

  localparam int TIMEOUT_CYCLES = (CLOCK_FREQUENCY / 1000) * TIMEOUT_MS;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (CMD_LENGTH > 1) ? $clog2(CMD_LENGTH) : 1;

  state_t                     state_q;
  logic [IW-1:0]              index_q;
  logic [TW-1:0]              timeout_q;
  logic [7:0]                 frame_buf [CMD_LENGTH];
  logic [CMD_LENGTH*8-1:0]    frame_word;
  reply_id_t                  reply_id_q;
  reply_idx_t                 reply_idx_q;
  reply_id_t                  match_id;
  logic [7:0]                 rom_byte;
  logic                       rom_last;
  logic                       pop;
  logic                       reply_wr;
  logic                       gap_advance;
`ifdef UART_CMD_ECHO_EN
  logic                       echo_wr;
`endif

  cmd_reply_rom u_rom (
    .reply_id   (reply_id_q),
    .reply_idx  (reply_idx_q),
    .reply_byte (rom_byte),
    .reply_last (rom_last)
  );

  // FIFO strobes are combinational so they always reflect this cycle's flags; reset silences them
  always_comb begin
    pop      = !reset && (state_q == S_RECV) && !bus.rx_fifo_empty;
    reply_wr = !reset && (state_q == S_REPLY) && !bus.tx_fifo_full;
`ifdef UART_CMD_ECHO_EN
    echo_wr     = !reset && (state_q == S_GAP) && !bus.tx_fifo_full;
    gap_advance = echo_wr;
`else
    gap_advance = 1'b1;
`endif
  end

  // Drive the FIFO-side outputs; echo (when built in) shares the TX push port in S_GAP
  always_comb begin
    bus.rx_fifo_read_en  = pop;
    bus.tx_fifo_write_en = reply_wr;
    bus.tx_fifo_data_in  = reply_wr ? rom_byte : 8'h00;
`ifdef UART_CMD_ECHO_EN
    if (echo_wr) begin
      bus.tx_fifo_write_en = 1'b1;
      bus.tx_fifo_data_in  = frame_buf[index_q];
    end
`endif
  end

  // Flatten the frame with the first received byte in the top byte lane and classify it
  always_comb begin
    frame_word = '0;
    for (int i = 0; i < CMD_LENGTH; i++) begin
      frame_word[(CMD_LENGTH-1-i)*8 +: 8] = frame_buf[i];
    end
    if (frame_word == (CMD_LENGTH*8)'(CMD_TEST)) begin
      match_id = RPL_OK;
    end else if (frame_word == (CMD_LENGTH*8)'(CMD_PING)) begin
      match_id = RPL_PONG;
    end else begin
      match_id = RPL_ERR;
    end
  end

  // Capture each popped byte into its frame slot; contents are don't-care until a frame completes
  always_ff @(posedge clock) begin
    if (pop) begin
      frame_buf[index_q] <= bus.rx_fifo_data_out;
    end
  end

  // Main sequencer: receive with inter-byte timeout, settle gap, classify, then stream the reply
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_RECV;
      index_q         <= '0;
      timeout_q       <= '0;
      reply_id_q      <= RPL_OK;
      reply_idx_q     <= '0;
      cmd_pass_toggle <= 1'b0;
      cmd_fail_toggle <= 1'b0;
      cmd_count       <= 8'h00;
    end else begin
      case (state_q)
        S_RECV: begin
          if (pop) begin
            timeout_q <= '0;
            state_q   <= S_GAP;
          end else if (index_q != '0) begin
            if (timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
              index_q   <= '0;
              timeout_q <= '0;
            end else begin
              timeout_q <= timeout_q + TW'(1);
            end
          end
        end
        S_GAP: begin
          if (gap_advance) begin
            if (index_q == IW'(CMD_LENGTH - 1)) begin
              index_q <= '0;
              state_q <= S_PARSE;
            end else begin
              index_q <= index_q + IW'(1);
              state_q <= S_RECV;
            end
          end
        end
        S_PARSE: begin
          reply_id_q  <= match_id;
          reply_idx_q <= '0;
          cmd_count   <= cmd_count + 8'd1;
          if (match_id == RPL_ERR) begin
            cmd_fail_toggle <= ~cmd_fail_toggle;
          end else begin
            cmd_pass_toggle <= ~cmd_pass_toggle;
          end
          state_q <= S_REPLY;
        end
        S_REPLY: begin
          if (reply_wr) begin
            if (rom_last) begin
              reply_idx_q <= '0;
              state_q     <= S_RECV;
            end else begin
              reply_idx_q <= reply_idx_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= S_RECV;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser.
// Models the RX FIFO as a queue, records every TX push and RX pop, and
// compares the TX byte stream, toggles and frame count against a reply
// model built from the command table. Honours UART_CMD_ECHO_EN.
module tb_uart_cmd_parser;

  localparam int CLK_FREQ       = 100000;
  localparam int TMO_MS         = 10;
  localparam int TIMEOUT_CYCLES = (CLK_FREQ / 1000) * TMO_MS;
`ifdef UART_CMD_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_pass_toggle;
  logic       cmd_fail_toggle;
  logic [7:0] cmd_count;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .CLOCK_FREQUENCY (CLK_FREQ),
    .CMD_LENGTH      (4),
    .TIMEOUT_MS      (TMO_MS)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus),
    .cmd_pass_toggle (cmd_pass_toggle),
    .cmd_fail_toggle (cmd_fail_toggle),
    .cmd_count       (cmd_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  byte unsigned rx_q[$];
  byte unsigned tx_got[$];
  int           tx_cycle[$];
  int           pop_cycle[$];
  int           cycle      = 0;
  int           pop_count  = 0;
  int           violations = 0;
  bit           pop_req    = 1'b0;

  int exp_pass  = 0;
  int exp_fail  = 0;
  int exp_count = 0;

  // Cycle counter used to timestamp pops and pushes
  always @(posedge clock) cycle++;

  // RX FIFO model: retire the popped head just after the edge, then present the new head
  always @(posedge clock) begin
    #1;
    if (pop_req) begin
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      pop_req = 1'b0;
    end
    bus.rx_fifo_empty    = (rx_q.size() == 0);
    bus.rx_fifo_data_out = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  // Mid-cycle monitor: log pops and pushes and note any handshake rule broken
  always @(negedge clock) begin
    if (bus.rx_fifo_read_en === 1'b1) begin
      if (bus.rx_fifo_empty !== 1'b0) violations++;
      pop_count++;
      pop_cycle.push_back(cycle);
      pop_req = 1'b1;
    end
    if (bus.tx_fifo_write_en === 1'b1) begin
      if (bus.tx_fifo_full !== 1'b0) violations++;
      tx_got.push_back(bus.tx_fifo_data_in);
      tx_cycle.push_back(cycle);
    end
    if (!ECHO && bus.rx_fifo_read_en === 1'b1 && bus.tx_fifo_write_en === 1'b1) violations++;
  end

  // Reply model straight from the command table
  function automatic string reply_text(input string cmd);
    if (cmd == "TEST") return "OK\r\n";
    if (cmd == "PING") return "PONG\r\n";
    return "ERR\r\n";
  endfunction

  task automatic model_frame(input string cmd, inout string exp_tx);
    if (ECHO) exp_tx = {exp_tx, cmd};
    exp_tx = {exp_tx, reply_text(cmd)};
    if (cmd == "TEST" || cmd == "PING") exp_pass++;
    else exp_fail++;
    exp_count++;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) rx_q.push_back(s.getc(i));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    tx_got.delete();
    tx_cycle.delete();
    pop_cycle.delete();
    pop_count  = 0;
    violations = 0;
    exp_pass   = 0;
    exp_fail   = 0;
    exp_count  = 0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    rx_q.delete();
    pop_req = 1'b0;
    bus.tx_fifo_full = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    clear_log();
  endtask

  // Bounded wait for n TX bytes, optionally with random TX-full backpressure
  task automatic wait_tx(input int n, input int budget, input bit rand_full, input string tag);
    int left = budget;
    while (tx_got.size() < n && left > 0) begin
      @(posedge clock); #1;
      if (rand_full) bus.tx_fifo_full = ($urandom_range(0, 3) == 0);
      left--;
    end
    bus.tx_fifo_full = 1'b0;
    checks++;
    if (tx_got.size() < n) begin
      errors++;
      $display("[TB] FAIL %s wait_tx got %0d bytes want %0d", tag, tx_got.size(), n);
    end
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    push_str("AB");
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (bus.rx_fifo_read_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_read_en got %b want 0", bus.rx_fifo_read_en); end
    checks++; if (bus.tx_fifo_write_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_write_en got %b want 0", bus.tx_fifo_write_en); end
    checks++; if (bus.tx_fifo_data_in !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_in got %h want 00", bus.tx_fifo_data_in); end
    checks++; if (cmd_pass_toggle !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass got %b want 0", cmd_pass_toggle); end
    checks++; if (cmd_fail_toggle !== 1'b0) begin errors++; $display("[TB] FAIL reset_fail got %b want 0", cmd_fail_toggle); end
    checks++; if (cmd_count !== 8'h00) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", cmd_count); end
    @(posedge clock); #1;
    rx_q.delete();
    pop_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    clear_log();
    @(negedge clock);
    checks++; if (bus.rx_fifo_read_en !== 1'b0) begin errors++; $display("[TB] FAIL idle_read_en got %b want 0", bus.rx_fifo_read_en); end
    @(posedge clock); #1;
  endtask

  task automatic test_test_cmd();
    string exp = "";
    int rs;
    do_reset();
    model_frame("TEST", exp);
    push_str("TEST");
    wait_tx(exp.len(), 200, 1'b0, "test_cmd");
    idle(10);
    checks++; if (tx_got.size() != exp.len()) begin errors++; $display("[TB] FAIL test_cmd tx_len got %0d want %0d", tx_got.size(), exp.len()); end
    for (int i = 0; i < exp.len() && i < tx_got.size(); i++) begin
      logic [7:0] e = exp.getc(i);
      checks++; if (tx_got[i] !== e) begin errors++; $display("[TB] FAIL test_cmd tx[%0d] got %h want %h", i, tx_got[i], e); end
    end
    checks++; if (pop_count != 4) begin errors++; $display("[TB] FAIL test_cmd pops got %0d want 4", pop_count); end
    checks++; if (cmd_pass_toggle !== 1'(exp_pass % 2)) begin errors++; $display("[TB] FAIL test_cmd pass got %b want %0d", cmd_pass_toggle, exp_pass % 2); end
    checks++; if (cmd_fail_toggle !== 1'b0) begin errors++; $display("[TB] FAIL test_cmd fail got %b want 0", cmd_fail_toggle); end
    checks++; if (cmd_count !== 8'(exp_count)) begin errors++; $display("[TB] FAIL test_cmd count got %0d want %0d", cmd_count, exp_count); end
    rs = ECHO ? 4 : 0;
    checks++;
    if (tx_cycle.size() <= rs || pop_cycle.size() < 4) begin
      errors++; $display("[TB] FAIL test_cmd latency got no sample want 3");
    end else if (tx_cycle[rs] - pop_cycle[3] != 3) begin
      errors++; $display("[TB] FAIL test_cmd latency got %0d want 3", tx_cycle[rs] - pop_cycle[3]);
    end
    checks++; if (violations != 0) begin errors++; $display("[TB] FAIL test_cmd handshake got %0d violations want 0", violations); end
  endtask

  task automatic test_ping_err();
    string exp = "";
    do_reset();
    model_frame("PING", exp);
    push_str("PING");
    wait_tx(exp.len(), 200, 1'b0, "ping");
    model_frame("XYZW", exp);
    push_str("XYZW");
    wait_tx(exp.len(), 200, 1'b0, "err");
    idle(10);
    checks++; if (tx_got.size() != exp.len()) begin errors++; $display("[TB] FAIL ping_err tx_len got %0d want %0d", tx_got.size(), exp.len()); end
    for (int i = 0; i < exp.len() && i < tx_got.size(); i++) begin
      logic [7:0] e = exp.getc(i);
      checks++; if (tx_got[i] !== e) begin errors++; $display("[TB] FAIL ping_err tx[%0d] got %h want %h", i, tx_got[i], e); end
    end
    checks++; if (cmd_fail_toggle !== 1'(exp_fail % 2)) begin errors++; $display("[TB] FAIL ping_err fail got %b want %0d", cmd_fail_toggle, exp_fail % 2); end
    checks++; if (cmd_pass_toggle !== 1'(exp_pass % 2)) begin errors++; $display("[TB] FAIL ping_err pass got %b want %0d", cmd_pass_toggle, exp_pass % 2); end
    checks++; if (cmd_count !== 8'(exp_count)) begin errors++; $display("[TB] FAIL ping_err count got %0d want %0d", cmd_count, exp_count); end
    checks++; if (pop_count != 8) begin errors++; $display("[TB] FAIL ping_err pops got %0d want 8", pop_count); end
    checks++; if (violations != 0) begin errors++; $display("[TB] FAIL ping_err handshake got %0d violations want 0", violations); end
  endtask

  task automatic test_timeout();
    string exp = "";
    int left = 100;
    do_reset();
    push_str("TE");
    if (ECHO) exp = "TE";
    while (pop_count < 2 && left > 0) begin @(posedge clock); #1; left--; end
    checks++; if (pop_count < 2) begin errors++; $display("[TB] FAIL timeout partial_pops got %0d want 2", pop_count); end
    idle(TIMEOUT_CYCLES + 5);
    checks++; if (tx_got.size() != exp.len()) begin errors++; $display("[TB] FAIL timeout quiet_tx got %0d want %0d", tx_got.size(), exp.len()); end
    model_frame("TEST", exp);
    push_str("TEST");
    wait_tx(exp.len(), 200, 1'b0, "timeout");
    idle(10);
    checks++; if (tx_got.size() != exp.len()) begin errors++; $display("[TB] FAIL timeout tx_len got %0d want %0d", tx_got.size(), exp.len()); end
    for (int i = 0; i < exp.len() && i < tx_got.size(); i++) begin
      logic [7:0] e = exp.getc(i);
      checks++; if (tx_got[i] !== e) begin errors++; $display("[TB] FAIL timeout tx[%0d] got %h want %h", i, tx_got[i], e); end
    end
    checks++; if (cmd_fail_toggle !== 1'b0) begin errors++; $display("[TB] FAIL timeout fail got %b want 0", cmd_fail_toggle); end
    checks++; if (cmd_count !== 8'(exp_count)) begin errors++; $display("[TB] FAIL timeout count got %0d want %0d", cmd_count, exp_count); end
  endtask

  task automatic test_backpressure();
    string exp = "";
    int start = ECHO ? 4 : 0;
    do_reset();
    model_frame("TEST", exp);
    push_str("TEST");
    wait_tx(start + 2, 200, 1'b0, "bp_pre");
    bus.tx_fifo_full = 1'b1;
    repeat (20) @(posedge clock);
    @(negedge clock);
    checks++; if (tx_got.size() != start + 2) begin errors++; $display("[TB] FAIL backpressure held_tx got %0d want %0d", tx_got.size(), start + 2); end
    @(posedge clock); #1;
    bus.tx_fifo_full = 1'b0;
    wait_tx(exp.len(), 200, 1'b0, "bp_post");
    idle(10);
    checks++; if (tx_got.size() != exp.len()) begin errors++; $display("[TB] FAIL backpressure tx_len got %0d want %0d", tx_got.size(), exp.len()); end
    for (int i = 0; i < exp.len() && i < tx_got.size(); i++) begin
      logic [7:0] e = exp.getc(i);
      checks++; if (tx_got[i] !== e) begin errors++; $display("[TB] FAIL backpressure tx[%0d] got %h want %h", i, tx_got[i], e); end
    end
    checks++; if (violations != 0) begin errors++; $display("[TB] FAIL backpressure handshake got %0d violations want 0", violations); end
  endtask

  task automatic test_reset_mid_reply();
    string exp = "";
    int start = ECHO ? 4 : 0;
    do_reset();
    push_str("TEST");
    wait_tx(start + 2, 200, 1'b0, "mid_pre");
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++; if (tx_got.size() != start + 2) begin errors++; $display("[TB] FAIL mid_reply cut_tx got %0d want %0d", tx_got.size(), start + 2); end
    clear_log();
    model_frame("PING", exp);
    push_str("PING");
    wait_tx(exp.len(), 200, 1'b0, "mid_post");
    idle(10);
    checks++; if (tx_got.size() != exp.len()) begin errors++; $display("[TB] FAIL mid_reply tx_len got %0d want %0d", tx_got.size(), exp.len()); end
    for (int i = 0; i < exp.len() && i < tx_got.size(); i++) begin
      logic [7:0] e = exp.getc(i);
      checks++; if (tx_got[i] !== e) begin errors++; $display("[TB] FAIL mid_reply tx[%0d] got %h want %h", i, tx_got[i], e); end
    end
    checks++; if (cmd_count !== 8'(exp_count)) begin errors++; $display("[TB] FAIL mid_reply count got %0d want %0d", cmd_count, exp_count); end
    checks++; if (cmd_pass_toggle !== 1'(exp_pass % 2)) begin errors++; $display("[TB] FAIL mid_reply pass got %b want %0d", cmd_pass_toggle, exp_pass % 2); end
  endtask

  task automatic test_random();
    string exp = "";
    string cmd;
    do_reset();
    for (int f = 0; f < 12; f++) begin
      case ($urandom_range(0, 2))
        0: cmd = "TEST";
        1: cmd = "PING";
        default: begin
          cmd = "AAAA";
          for (int k = 0; k < 4; k++) cmd.putc(k, byte'($urandom_range(65, 90)));
        end
      endcase
      model_frame(cmd, exp);
      push_str(cmd);
    end
    wait_tx(exp.len(), 3000, 1'b1, "random");
    idle(10);
    checks++; if (tx_got.size() != exp.len()) begin errors++; $display("[TB] FAIL random tx_len got %0d want %0d", tx_got.size(), exp.len()); end
    for (int i = 0; i < exp.len() && i < tx_got.size(); i++) begin
      logic [7:0] e = exp.getc(i);
      checks++; if (tx_got[i] !== e) begin errors++; $display("[TB] FAIL random tx[%0d] got %h want %h", i, tx_got[i], e); end
    end
    checks++; if (cmd_count !== 8'(exp_count)) begin errors++; $display("[TB] FAIL random count got %0d want %0d", cmd_count, exp_count); end
    checks++; if (cmd_pass_toggle !== 1'(exp_pass % 2)) begin errors++; $display("[TB] FAIL random pass got %b want %0d", cmd_pass_toggle, exp_pass % 2); end
    checks++; if (cmd_fail_toggle !== 1'(exp_fail % 2)) begin errors++; $display("[TB] FAIL random fail got %b want %0d", cmd_fail_toggle, exp_fail % 2); end
    checks++; if (pop_count != 48) begin errors++; $display("[TB] FAIL random pops got %0d want 48", pop_count); end
    checks++; if (violations != 0) begin errors++; $display("[TB] FAIL random handshake got %0d violations want 0", violations); end
  endtask

  // Hard stop in case something upstream of a bounded wait never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  // Scenario sequence
  initial begin
    bus.tx_fifo_full = 1'b0;
    test_reset();
    test_test_cmd();
    test_ping_err();
    test_timeout();
    test_backpressure();
    test_reset_mid_reply();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
